visibility_packer: RTL and testbench
====================================

# visibility_packer

Consumer end of the correlator accumulator output stream. Takes the no-backpressure visibility stream (`valid_i`/`last_i`/`revis_i`/`imvis_i`, one complex visibility per valid cycle, `last_i` on the final pair of a frame) and buffers whole frames in a FIFO. It re-emits each frame as an AXI4-Stream with `tready` backpressure, two beats per visibility (real, then imaginary). Frames are admitted or dropped atomically, so a stalled sink never corrupts framing.

## Interface
Parameters:
- `WIDTH`, 36, visibility component width; output beat width.
- `PAIRS`, 540, visibilities per frame (CORES*TRATE).
- `DEPTH`, 1024, FIFO entries; must be a power of two and ≥ PAIRS.
- `ABITS`, 10, log2(DEPTH).

Ports:
- `clock` in 1: sole clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `valid_i` in 1: input visibility present; cannot be stalled.
- `last_i` in 1: final visibility of the frame; qualified by `valid_i`.
- `revis_i` in WIDTH: real component.
- `imvis_i` in WIDTH: imaginary component.
- `m_tdata` out WIDTH: output beat.
- `m_tvalid` out 1: beat valid.
- `m_tready` in 1: sink ready.
- `m_tlast` out 1: final beat of frame.
- `m_tuser` out 1: 0 = real beat, 1 = imaginary beat.
- `overflow_o` out 1: sticky; an admitted frame lost a sample.
- `drops_o` out 16: saturating count of frames dropped at admission.

## Operation
- Input FSM states: WAIT (reset state), ACCEPT, DISCARD.
- In WAIT, `valid_i` marks a frame start. If `DEPTH - occupancy ≥ PAIRS`, the sample is written and the FSM goes to ACCEPT. Otherwise the sample is discarded, `drops_o` increments (saturating at 0xFFFF), and the FSM goes to DISCARD.
- Occupancy for admission is the count at that cycle, before any same-cycle pop (conservative).
- If the frame-start sample also has `last_i`, it is handled as above and the FSM stays in WAIT.
- ACCEPT: write every valid sample; `valid_i & last_i` returns the FSM to WAIT.
- DISCARD: drop every valid sample; `valid_i & last_i` returns the FSM to WAIT.
- FIFO entry holds {last, imvis, revis}, 2*WIDTH+1 bits.
- Malformed frame in ACCEPT (FIFO full on a write): drop the sample and set `overflow_o`. If that sample carried `last_i`, still return to WAIT.
- Output side: a beat toggle selects real or imaginary from the head entry.
  - Real beat: `m_tuser`=0, `m_tlast`=0.
  - Imaginary beat: `m_tuser`=1, `m_tlast` = the entry's last flag.
  - The entry is popped on the imaginary-beat handshake.
- AXI rules:
  - Once `m_tvalid` is high, `m_tdata`/`m_tuser`/`m_tlast` hold until `m_tvalid & m_tready`.
  - `m_tvalid` never drops without a handshake.
- Simultaneous write and pop in one cycle: occupancy is unchanged; both operations take effect.
- Pointer wrap: ABITS-bit read/write pointers with an extra wrap bit to distinguish full from empty.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tuser`=0, `m_tdata`=0, `overflow_o`=0, `drops_o`=0, FSM=WAIT, FIFO empty, beat toggle=real.
- Reset mid-frame discards all FIFO contents and any in-flight beat. Input resumes in WAIT, so a partial frame after reset is treated as a new frame start.
- Latency: sample accepted at edge N into an empty FIFO → real beat has `m_tvalid` high in cycle N+2. Its imaginary beat follows at N+3 if `m_tready` is held high.
- Throughput: the output sustains 1 beat/cycle. The input may arrive at up to 1 sample/cycle, which is twice the output entry rate, so bursts are absorbed by the FIFO.
- The FIFO read is registered; there is no combinational path from `m_tready` to `m_tvalid`.

## Structure
- Shared package `correlator_pkg`: WIDTH, PAIRS, CORES, TRATE constants and the FIFO-entry packing layout. Input FSM state encoding is local to this block.
- Sub-module `vis_fifo`: synchronous single-clock FIFO, parameters DEPTH and entry width. Provides write/read, `full`, `empty` and `count[ABITS:0]`, with a registered read-data output. The packer contains the FSM, admission check, beat serialiser and counters.

## Test plan
- Single frame, `PAIRS`=4, `m_tready`=1: inputs (re,im)=(1,2),(3,4),(5,6),(7,8) → beats 1,2,3,4,5,6,7,8; `m_tuser` alternates 0,1; `m_tlast` only on beat 8; first `m_tvalid` two cycles after the first `valid_i`.
- Backpressure: `m_tready` toggling every cycle over a full frame → beat sequence identical to the `m_tready`=1 case; data stable while stalled; no loss; `overflow_o`=0.
- Admission drop (`DEPTH`=8, `PAIRS`=4, `m_tready`=0): three frames offered → frames 1 and 2 stored, frame 3 dropped, `drops_o`=1. Then release `m_tready` → exactly 16 beats with `m_tlast` on beats 8 and 16.
- Malformed frame: 9 samples with no `last_i` in ACCEPT, `DEPTH`=8, `m_tready`=0 → 8 stored; `overflow_o` goes to 1 on the 9th sample and stays 1.
- `drops_o` saturation: preload 0xFFFE via repeated drops → the next two drops read 0xFFFF and 0xFFFF.
- Reset mid-output: assert `reset_n`=0 for one cycle during a frame → `m_tvalid`=0 next cycle, `drops_o`=0; a following clean frame is delivered correctly.

Source files
------------

// File: rtl/correlator_pkg.sv
// Shared correlator constants and the FIFO-entry packing layout.
// An entry is {last, imvis, revis}: revis in the low WIDTH bits, imvis above it, last on top.
package correlator_pkg;

    localparam int WIDTH = 36;
    localparam int CORES = 27;
    localparam int TRATE = 20;
    localparam int PAIRS = CORES * TRATE;

    function automatic int entry_bits(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int entry_im_lsb(input int w);
        return w;
    endfunction

    function automatic int entry_last_bit(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/vis_fifo.sv
// Single-clock FIFO with an extra pointer wrap bit and a registered read-data output.
// Read data updates only on a successful pop; it holds the popped entry afterwards.
module vis_fifo #(
    parameter int DEPTH = 1024,
    parameter int EW    = 73,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_en_i,
    input  logic [EW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [EW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rd_data_q;
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign count_o   = wptr_q - rptr_q;
    assign rd_data_o = rd_data_q;
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_rd) begin
                rd_data_q <= mem_q[rptr_q[AW-1:0]];
                rptr_q    <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/visibility_packer.sv
// Buffers whole visibility frames and re-emits them as an AXI4-Stream, real beat then imaginary beat.
// Frames are admitted or dropped at their first sample so a stalled sink never breaks framing.
module visibility_packer #(
    parameter int WIDTH = correlator_pkg::WIDTH,
    parameter int PAIRS = correlator_pkg::PAIRS,
    parameter int DEPTH = 1024,
    parameter int ABITS = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] revis_i,
    input  logic [WIDTH-1:0] imvis_i,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic             overflow_o,
    output logic [15:0]      drops_o
);

    import correlator_pkg::*;

    localparam int EW       = entry_bits(WIDTH);
    localparam int IM_LSB   = entry_im_lsb(WIDTH);
    localparam int LAST_BIT = entry_last_bit(WIDTH);
    localparam logic [ABITS:0] DEPTH_W   = (ABITS+1)'(DEPTH);
    localparam logic [ABITS:0] ADMIT_MAX = (ABITS+1)'(DEPTH - PAIRS);

    typedef enum logic [1:0] {S_WAIT, S_ACCEPT, S_DISCARD} in_state_e;

    in_state_e      state_q, state_d;
    logic [ABITS:0] fifo_count;
    logic [ABITS:0] occ;
    logic           fifo_full, fifo_empty;
    logic           wr_en, rd_en;
    logic [EW-1:0]  wr_data, rd_data;
    logic           head_valid_q, head_valid_d;
    logic           beat_q, beat_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    drops_q, drops_d;
    logic           store_full, space_ok, hs, hs_im;

    vis_fifo #(.DEPTH(DEPTH), .EW(EW), .AW(ABITS)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // The entry in the output register still counts as stored until its imaginary beat is taken.
    assign occ        = fifo_count + {{ABITS{1'b0}}, head_valid_q};
    assign store_full = fifo_full | (occ == DEPTH_W);
    assign space_ok   = (occ <= ADMIT_MAX);
    assign wr_data    = {last_i, imvis_i, revis_i};

    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        overflow_d = overflow_q;
        drops_d    = drops_q;
        case (state_q)
            S_WAIT: begin
                if (valid_i) begin
                    if (space_ok) begin
                        wr_en   = 1'b1;
                        state_d = last_i ? S_WAIT : S_ACCEPT;
                    end else begin
                        if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
                        state_d = last_i ? S_WAIT : S_DISCARD;
                    end
                end
            end
            S_ACCEPT: begin
                if (valid_i) begin
                    if (store_full) overflow_d = 1'b1;
                    else            wr_en      = 1'b1;
                    if (last_i) state_d = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (valid_i && last_i) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign hs           = head_valid_q & m_tready;
    assign hs_im        = hs & beat_q;
    assign rd_en        = ~fifo_empty & (~head_valid_q | hs_im);
    assign head_valid_d = rd_en | (head_valid_q & ~hs_im);
    assign beat_d       = hs ? ~beat_q : beat_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_WAIT;
            head_valid_q <= 1'b0;
            beat_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drops_q      <= '0;
        end else begin
            state_q      <= state_d;
            head_valid_q <= head_valid_d;
            beat_q       <= beat_d;
            overflow_q   <= overflow_d;
            drops_q      <= drops_d;
        end
    end

    assign m_tvalid   = head_valid_q;
    assign m_tuser    = beat_q;
    assign m_tdata    = beat_q ? rd_data[IM_LSB +: WIDTH] : rd_data[WIDTH-1:0];
    assign m_tlast    = beat_q & rd_data[LAST_BIT];
    assign overflow_o = overflow_q;
    assign drops_o    = drops_q;

endmodule

// File: tb/tb_visibility_packer.sv
// Directed bench for visibility_packer with a small FIFO (DEPTH=8, PAIRS=4).
module tb_visibility_packer;

    localparam int W  = 8;
    localparam int P  = 4;
    localparam int D  = 8;
    localparam int AB = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          valid_i, last_i;
    logic [W-1:0]  revis_i, imvis_i;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic          overflow_o;
    logic [15:0]   drops_o;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_data[$];
    logic         rx_user[$];
    logic         rx_last[$];

    logic         bp_v, bp_r, bp_u, bp_l;
    logic [W-1:0] bp_d;

    always #5 clock = ~clock;

    visibility_packer #(.WIDTH(W), .PAIRS(P), .DEPTH(D), .ABITS(AB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .revis_i    (revis_i),
        .imvis_i    (imvis_i),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .overflow_o (overflow_o),
        .drops_o    (drops_o)
    );

    // Handshake recorder; m_tready/m_tvalid are stable at the falling edge.
    always @(negedge clock) begin
        if (reset_n && m_tvalid && m_tready) begin
            rx_data.push_back(m_tdata);
            rx_user.push_back(m_tuser);
            rx_last.push_back(m_tlast);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_user.delete();
        rx_last.delete();
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0;
        last_i  = 1'b0;
        revis_i = '0;
        imvis_i = '0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        clear_rx();
    endtask

    task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        valid_i = 1'b1;
        revis_i = re;
        imvis_i = im;
        last_i  = last;
        cyc();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int budget;
        budget = 0;
        while (rx_data.size() < n && budget < 200) begin
            cyc();
            budget++;
        end
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", m_tlast); end
        checks++; if (m_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got=%b want=0", m_tuser); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow_o); end
        checks++; if (drops_o !== 16'h0) begin errors++; $display("FAIL reset_drops got=%h want=0", drops_o); end
        reset_n = 1'b1;
        cyc();
        clear_rx();
    endtask

    task automatic test_single_frame();
        logic tv[4];
        clear_rx();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_sample(W'(2*i+1), W'(2*i+2), i == 3);
            tv[i] = m_tvalid;
        end
        for (int k = 1; k <= 8; k++) exp_q.push_back(W'(k));
        checks++; if (tv[0] !== 1'b0) begin errors++; $display("FAIL single_latency_early got=%b want=0", tv[0]); end
        checks++; if (tv[1] !== 1'b1) begin errors++; $display("FAIL single_latency_n2 got=%b want=1", tv[1]); end
        wait_beats(8);
        checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL single_count got=%0d want=8", rx_data.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_data.size(); k++) begin
            checks++;
            if (rx_data[k] !== exp_q[k] || rx_user[k] !== (k % 2 == 1) || rx_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL single_beat%0d got data=%0d user=%b last=%b want data=%0d user=%b last=%b",
                         k, rx_data[k], rx_user[k], rx_last[k], exp_q[k], (k % 2 == 1), (k == 7));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 8; k++) exp_q.push_back(W'(8'h11 + k));
        bp_v = 1'b0;
        bp_r = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_sample(W'(8'h11 + 2*i), W'(8'h12 + 2*i), i == 3);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    if (bp_v && !bp_r) begin
                        checks++;
                        if (m_tvalid !== 1'b1 || m_tdata !== bp_d || m_tuser !== bp_u || m_tlast !== bp_l) begin
                            errors++;
                            $display("FAIL bp_hold cycle%0d got v=%b d=%h u=%b l=%b want v=1 d=%h u=%b l=%b",
                                     c, m_tvalid, m_tdata, m_tuser, m_tlast, bp_d, bp_u, bp_l);
                        end
                    end
                    m_tready = ~m_tready;
                    bp_r = m_tready;
                    bp_v = m_tvalid;
                    bp_d = m_tdata;
                    bp_u = m_tuser;
                    bp_l = m_tlast;
                    cyc();
                end
            end
        join
        m_tready = 1'b1;
        wait_beats(8);
        checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", rx_data.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_data.size(); k++) begin
            checks++;
            if (rx_data[k] !== exp_q[k] || rx_user[k] !== (k % 2 == 1) || rx_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d got data=%h user=%b last=%b want data=%h user=%b last=%b",
                         k, rx_data[k], rx_user[k], rx_last[k], exp_q[k], (k % 2 == 1), (k == 7));
            end
        end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL bp_overflow got=%b want=0", overflow_o); end
    endtask

    task automatic test_admission_drop();
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++)
                send_sample(W'(8'h20 + 8*f + 2*i), W'(8'h21 + 8*f + 2*i), i == 3);
        for (int k = 0; k < 16; k++) exp_q.push_back(W'(8'h20 + k));
        cyc();
        cyc();
        checks++; if (drops_o !== 16'd1) begin errors++; $display("FAIL adm_drops got=%0d want=1", drops_o); end
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== W'(8'h20)) begin
            errors++; $display("FAIL adm_head got v=%b d=%h want v=1 d=20", m_tvalid, m_tdata);
        end
        m_tready = 1'b1;
        wait_beats(16);
        checks++; if (rx_data.size() != 16) begin errors++; $display("FAIL adm_count got=%0d want=16", rx_data.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_data.size(); k++) begin
            checks++;
            if (rx_data[k] !== exp_q[k] || rx_user[k] !== (k % 2 == 1) || rx_last[k] !== (k == 7 || k == 15)) begin
                errors++;
                $display("FAIL adm_beat%0d got data=%h user=%b last=%b want data=%h user=%b last=%b",
                         k, rx_data[k], rx_user[k], rx_last[k], exp_q[k], (k % 2 == 1), (k == 7 || k == 15));
            end
        end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL adm_drained got=%b want=0", m_tvalid); end
    endtask

    task automatic test_malformed();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_sample(W'(8'h40 + i), W'(8'h50 + i), 1'b0);
            if (i == 7) begin
                checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mal_ovf_at8 got=%b want=0", overflow_o); end
            end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL mal_ovf_at9 got=%b want=1", overflow_o); end
        send_sample(W'(8'h7E), W'(8'h7F), 1'b1);
        repeat (3) cyc();
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL mal_ovf_sticky got=%b want=1", overflow_o); end
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(W'(8'h40 + k));
            exp_q.push_back(W'(8'h50 + k));
        end
        m_tready = 1'b1;
        wait_beats(16);
        checks++; if (rx_data.size() != 16) begin errors++; $display("FAIL mal_count got=%0d want=16", rx_data.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_data.size(); k++) begin
            checks++;
            if (rx_data[k] !== exp_q[k] || rx_user[k] !== (k % 2 == 1) || rx_last[k] !== 1'b0) begin
                errors++;
                $display("FAIL mal_beat%0d got data=%h user=%b last=%b want data=%h user=%b last=0",
                         k, rx_data[k], rx_user[k], rx_last[k], exp_q[k], (k % 2 == 1));
            end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL mal_ovf_after got=%b want=1", overflow_o); end
    endtask

    task automatic test_drops_saturation();
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                send_sample(W'(8'h30 + 8*f + 2*i), W'(8'h31 + 8*f + 2*i), i == 3);
        valid_i = 1'b1;
        last_i  = 1'b1;
        revis_i = W'(8'hAA);
        imvis_i = W'(8'hBB);
        repeat (65534) cyc();
        checks++; if (drops_o !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h want=fffe", drops_o); end
        cyc();
        checks++; if (drops_o !== 16'hFFFF) begin errors++; $display("FAIL sat_first got=%h want=ffff", drops_o); end
        cyc();
        checks++; if (drops_o !== 16'hFFFF) begin errors++; $display("FAIL sat_second got=%h want=ffff", drops_o); end
        idle_inputs();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL sat_overflow got=%b want=0", overflow_o); end
    endtask

    task automatic test_reset_mid_output();
        m_tready = 1'b1;
        repeat (3) cyc();
        send_sample(W'(8'h70), W'(8'h71), 1'b0);
        reset_n = 1'b0;
        cyc();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got=%b want=0", m_tvalid); end
        checks++; if (drops_o !== 16'h0) begin errors++; $display("FAIL rmid_drops got=%h want=0", drops_o); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rmid_tdata got=%h want=0", m_tdata); end
        reset_n = 1'b1;
        clear_rx();
        for (int i = 0; i < 4; i++) send_sample(W'(8'h60 + 2*i), W'(8'h61 + 2*i), i == 3);
        for (int k = 0; k < 8; k++) exp_q.push_back(W'(8'h60 + k));
        wait_beats(8);
        checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL rmid_count got=%0d want=8", rx_data.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_data.size(); k++) begin
            checks++;
            if (rx_data[k] !== exp_q[k] || rx_user[k] !== (k % 2 == 1) || rx_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL rmid_beat%0d got data=%h user=%b last=%b want data=%h user=%b last=%b",
                         k, rx_data[k], rx_user[k], rx_last[k], exp_q[k], (k % 2 == 1), (k == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_admission_drop();
        test_malformed();
        test_drops_saturation();
        test_reset_mid_output();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
